// File: rtl/wb_trace_fifo_pkg.sv
// Shared types and defaults for the writeback trace capture block.
// Imported by the trace FIFO top and its storage sub-module.
package rv32i_trace_pkg;

  localparam int DEF_DEPTH = 8;
  localparam int DEF_XLEN  = 32;
  localparam int DROP_W    = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  function automatic logic [DROP_W-1:0] sat_inc(
    input logic [DROP_W-1:0] v
  );
    return (&v) ? v : v + DROP_W'(1);
  endfunction

endpackage

// File: rtl/wb_trace_fifo_if.sv
// Consumer-side read port of the trace FIFO.
// master = FIFO (drives head entry), slave = consumer.
interface wb_trace_fifo_if #(
  parameter int XLEN = 32
);
  logic            rd_valid;
  logic            rd_ready;
  logic [XLEN-1:0] rd_pc;
  logic [XLEN-1:0] rd_wb;

  modport master (
    output rd_valid,
    output rd_pc,
    output rd_wb,
    input  rd_ready
  );

  modport slave (
    input  rd_valid,
    input  rd_pc,
    input  rd_wb,
    output rd_ready
  );
endinterface

// File: rtl/wb_trace_fifo_mem.sv
// Show-ahead trace storage: DEPTH entries of {pc, wb}.
// Owns pointers and occupancy; pop on empty is ignored.
module trace_fifo_mem
  import rv32i_trace_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int XLEN  = DEF_XLEN,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] push_pc,
  input  logic [XLEN-1:0] push_wb,
  output logic [XLEN-1:0] head_pc,
  output logic [XLEN-1:0] head_wb,
  output logic [CW-1:0]   count,
  output logic            full,
  output logic            empty
);

  logic [2*XLEN-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              pop_ok;
  logic              push_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop && !empty;
  // a full FIFO still accepts a push when the head leaves on the same edge
  assign push_ok = push && (!full || pop_ok);

  assign head_pc = mem[rd_ptr][2*XLEN-1:XLEN];
  assign head_wb = mem[rd_ptr][XLEN-1:0];

  // entry storage, cleared on reset so the head reads back zero
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push_ok) begin
      mem[wr_ptr] <= {push_pc, push_wb};
    end
  end

  // pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wb_trace_fifo.sv
// Writeback trace capture: detects retirements from PC changes
// and queues {pc, wb} pairs, tracking drops and retire count.
module wb_trace_fifo
  import rv32i_trace_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int XLEN  = DEF_XLEN,
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [XLEN-1:0]    pc_in,
  input  logic [XLEN-1:0]    wb_in,
  input  logic               capture_en,
  input  logic               clr_ovf,
  wb_trace_fifo_if.master    rd,
  output logic [CW-1:0]      count,
  output logic               overflow,
  output logic [DROP_W-1:0]  drop_cnt,
  output logic [XLEN-1:0]    retired
);

  state_t          state;
  state_t          state_nxt;
  logic [XLEN-1:0] pc_prev;
  logic [XLEN-1:0] wb_prev;
  logic            arm;
  logic            evt;
  logic            pop;
  logic            full;
  logic            empty;
  logic            drop;

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  state_nxt = capture_en ? S_ARM : S_IDLE;
      S_ARM:   state_nxt = capture_en ? S_RUN : S_IDLE;
      S_RUN:   state_nxt = capture_en ? S_RUN : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // per-state outputs: arm latches, run detects retirements
  always_comb begin
    arm = 1'b0;
    evt = 1'b0;
    unique case (state)
      S_ARM:   arm = 1'b1;
      S_RUN:   evt = capture_en && (pc_in != pc_prev);
      default: ;
    endcase
  end

  assign pop  = rd.rd_valid && rd.rd_ready;
  assign drop = evt && full && !pop;
  assign rd.rd_valid = !empty;

  // previous-instruction snapshot, pushed when the PC moves on
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_prev <= '0;
      wb_prev <= '0;
    end else if (arm || evt) begin
      pc_prev <= pc_in;
      wb_prev <= wb_in;
    end
  end

  // retirement counter, counts dropped entries too
  always_ff @(posedge clk) begin
    if (rst)      retired <= '0;
    else if (evt) retired <= retired + XLEN'(1);
  end

  // sticky overflow and drop counter; a drop beats a clear
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      drop_cnt <= clr_ovf ? DROP_W'(1) : sat_inc(drop_cnt);
    end else if (clr_ovf) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end
  end

  trace_fifo_mem #(
    .DEPTH (DEPTH),
    .XLEN  (XLEN)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .push    (evt),
    .pop     (pop),
    .push_pc (pc_prev),
    .push_wb (wb_prev),
    .head_pc (rd.rd_pc),
    .head_wb (rd.rd_wb),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

endmodule

// File: tb/tb_wb_trace_fifo.sv
// Randomized scoreboard bench for wb_trace_fifo.
// Queue-based reference model; monitor checks popped entries.
module tb_wb_trace_fifo;

  localparam int DEPTH = 8;
  localparam int XLEN  = 32;

  typedef enum int {M_IDLE, M_ARM, M_RUN} mstate_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [XLEN-1:0] pc_in;
  logic [XLEN-1:0] wb_in;
  logic            capture_en;
  logic            clr_ovf;
  logic [3:0]      count;
  logic            overflow;
  logic [15:0]     drop_cnt;
  logic [XLEN-1:0] retired;

  wb_trace_fifo_if #(.XLEN(XLEN)) rd_if ();

  wb_trace_fifo #(
    .DEPTH (DEPTH),
    .XLEN  (XLEN)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pc_in      (pc_in),
    .wb_in      (wb_in),
    .capture_en (capture_en),
    .clr_ovf    (clr_ovf),
    .rd         (rd_if),
    .count      (count),
    .overflow   (overflow),
    .drop_cnt   (drop_cnt),
    .retired    (retired)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // reference model
  mstate_t         m_st = M_IDLE;
  logic [63:0]     mq[$];
  logic [63:0]     sb[$];
  logic [XLEN-1:0] m_ppc = '0;
  logic [XLEN-1:0] m_pwb = '0;
  logic            m_ovf = 1'b0;
  int unsigned     m_drop = 0;
  logic [XLEN-1:0] m_ret = '0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // scoreboard monitor: every accepted read must match the model
  always @(negedge clk) begin
    if (!rst && rd_if.rd_valid && rd_if.rd_ready) begin
      if (sb.size() == 0) begin
        chk("pop_unexpected", 1, 0);
      end else begin
        logic [63:0] e;
        e = sb.pop_front();
        chk("rd_pc", rd_if.rd_pc, e[63:32]);
        chk("rd_wb", rd_if.rd_wb, e[31:0]);
      end
    end
  end

  task automatic model(input logic r, cap, input logic [31:0] pc,
                       input logic [31:0] wb, input logic rdy, clr);
    logic ev;
    logic dropped;
    ev = 1'b0;
    dropped = 1'b0;
    if (r) begin
      m_st = M_IDLE;
      mq.delete();
      sb.delete();
      m_ppc = '0;
      m_pwb = '0;
      m_ovf = 1'b0;
      m_drop = 0;
      m_ret = '0;
      return;
    end
    if (mq.size() > 0 && rdy) void'(mq.pop_front());
    case (m_st)
      M_IDLE: if (cap) m_st = M_ARM;
      M_ARM: begin
        m_ppc = pc;
        m_pwb = wb;
        m_st = cap ? M_RUN : M_IDLE;
      end
      default: begin
        if (!cap) m_st = M_IDLE;
        else if (pc != m_ppc) ev = 1'b1;
      end
    endcase
    if (ev) begin
      m_ret = m_ret + 1;
      if (mq.size() < DEPTH) begin
        mq.push_back({m_ppc, m_pwb});
        sb.push_back({m_ppc, m_pwb});
      end else begin
        dropped = 1'b1;
      end
      m_ppc = pc;
      m_pwb = wb;
    end
    if (dropped) begin
      m_ovf = 1'b1;
      m_drop = clr ? 1 : ((m_drop == 65535) ? m_drop : m_drop + 1);
    end else if (clr) begin
      m_ovf = 1'b0;
      m_drop = 0;
    end
  endtask

  task automatic step(input logic r, cap, input logic [31:0] pc,
                      input logic [31:0] wb, input logic rdy, clr);
    rst = r;
    capture_en = cap;
    pc_in = pc;
    wb_in = wb;
    rd_if.rd_ready = rdy;
    clr_ovf = clr;
    model(r, cap, pc, wb, rdy, clr);
    @(posedge clk);
    #1;
    chk("count", count, mq.size());
    chk("rd_valid", rd_if.rd_valid, mq.size() > 0);
    chk("overflow", overflow, m_ovf);
    chk("drop_cnt", drop_cnt, m_drop);
    chk("retired", retired, m_ret);
  endtask

  initial begin
    logic [31:0] pc;
    rst = 1'b1;
    capture_en = 1'b0;
    pc_in = '0;
    wb_in = '0;
    clr_ovf = 1'b0;
    rd_if.rd_ready = 1'b0;

    // reset state
    step(1, 0, 0, 0, 0, 0);
    chk("rst_rd_pc", rd_if.rd_pc, 0);
    chk("rst_rd_wb", rd_if.rd_wb, 0);
    chk("rst_count", count, 0);

    // basic capture 0->4->8
    step(0, 1, 0, 5, 0, 0);
    step(0, 1, 0, 5, 0, 0);
    step(0, 1, 4, 9, 0, 0);
    step(0, 1, 8, 13, 0, 0);
    chk("basic_retired", retired, 2);
    chk("basic_count", count, 2);
    chk("basic_head_pc", rd_if.rd_pc, 0);
    chk("basic_head_wb", rd_if.rd_wb, 5);
    for (int i = 0; i < 3; i++) step(0, 0, 8, 13, 1, 0);

    // overflow with 9 events
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    for (int i = 1; i <= 9; i++) step(0, 1, i * 4, i, 0, 0);
    chk("ovf_count", count, 8);
    chk("ovf_flag", overflow, 1);
    chk("ovf_drop", drop_cnt, 1);
    chk("ovf_retired", retired, 9);

    // drop and clear on the same edge
    step(0, 1, 40, 10, 0, 1);
    chk("dropclr_flag", overflow, 1);
    chk("dropclr_cnt", drop_cnt, 1);
    step(0, 1, 40, 10, 0, 1);
    chk("clr_flag", overflow, 0);
    chk("clr_cnt", drop_cnt, 0);

    // full, push and pop together
    step(0, 1, 44, 11, 1, 0);
    chk("fullpp_count", count, 8);
    chk("fullpp_flag", overflow, 0);

    // PC held: no retirements
    for (int i = 0; i < 10; i++) step(0, 1, 44, 11, 0, 0);
    chk("hold_retired", retired, 11);

    // reset mid-capture with count 5
    for (int i = 0; i < 3; i++) step(0, 1, 44, 11, 1, 0);
    chk("pre_rst_count", count, 5);
    step(1, 1, 48, 12, 0, 0);
    chk("midrst_count", count, 0);
    chk("midrst_valid", rd_if.rd_valid, 0);
    step(0, 1, 52, 13, 0, 0);
    step(0, 1, 52, 13, 0, 0);
    step(0, 1, 56, 14, 0, 0);
    chk("midrst_restart", count, 1);

    // randomized traffic
    pc = 32'h100;
    for (int i = 0; i < 3000; i++) begin
      logic r, cap, rdy, clr;
      r = ($urandom_range(0, 299) == 0);
      cap = ($urandom_range(0, 24) != 0);
      if ($urandom_range(0, 9) < 6) pc = pc + 4 * $urandom_range(1, 3);
      rdy = (i < 1500) ? ($urandom_range(0, 3) == 0)
                       : ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 39) == 0);
      step(r, cap, pc, $urandom, rdy, clr);
    end

    // drain
    for (int i = 0; i < DEPTH + 2; i++) step(0, 0, pc, 0, 1, 0);
    chk("sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
